// File: rtl/stdp_synapse_array.sv
// STDP synapse array: per-channel plastic weights with pair-based traces,
// host write/readback and a registered summed synaptic current.

module stdp_trace #(
    parameter int TRACE_W     = 8,
    parameter int TRACE_INC   = 64,
    parameter int DECAY_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               spike,
    output logic [TRACE_W-1:0] trace
);
    localparam logic [TRACE_W:0] INC  = (TRACE_W+1)'(TRACE_INC);
    localparam logic [TRACE_W:0] TMAX = {1'b0, {TRACE_W{1'b1}}};

    logic [TRACE_W:0]   sum;
    logic [TRACE_W-1:0] decay;
    logic [TRACE_W-1:0] trace_nxt;

    always_comb begin
        sum       = {1'b0, trace} + INC;
        decay     = trace >> DECAY_SHIFT;
        trace_nxt = trace;
        if (spike)
            trace_nxt = (sum > TMAX) ? {TRACE_W{1'b1}} : sum[TRACE_W-1:0];
        // small traces still drain to zero once the shift term vanishes
        else if (decay == '0 && trace != '0)
            trace_nxt = trace - TRACE_W'(1);
        else
            trace_nxt = trace - decay;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) trace <= '0;
        else          trace <= trace_nxt;
    end
endmodule

module stdp_lane #(
    parameter int WIDTH       = 8,
    parameter int TRACE_W     = 8,
    parameter int TRACE_INC   = 64,
    parameter int DECAY_SHIFT = 2,
    parameter int LTP_SHIFT   = 3,
    parameter int LTD_SHIFT   = 3,
    parameter int W_MIN       = 4,
    parameter int W_MAX       = 127,
    parameter int W_INIT      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               learn_en,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic [TRACE_W-1:0] post_trace,
    input  logic               wr_hit,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   weight,
    output logic [TRACE_W-1:0] pre_trace,
    output logic               ltp_nz,
    output logic               ltd_nz
);
    // signed working width, at least WIDTH+2, wide enough for any trace delta
    localparam int SW = ((WIDTH > TRACE_W) ? WIDTH : TRACE_W) + 2;

    logic [TRACE_W-1:0]   ltp;
    logic [TRACE_W-1:0]   ltd;
    logic signed [SW-1:0] w_sum;

    function automatic logic [WIDTH-1:0] clamp(input logic signed [SW-1:0] v);
        if (v < $signed(SW'(W_MIN)))      return WIDTH'(W_MIN);
        else if (v > $signed(SW'(W_MAX))) return WIDTH'(W_MAX);
        else                              return v[WIDTH-1:0];
    endfunction

    stdp_trace #(
        .TRACE_W    (TRACE_W),
        .TRACE_INC  (TRACE_INC),
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_pre_trace (
        .clk    (clk),
        .reset_n(reset_n),
        .spike  (pre_spike),
        .trace  (pre_trace)
    );

    always_comb begin
        ltp    = (learn_en && post_spike) ? (pre_trace >> LTP_SHIFT) : '0;
        ltd    = (learn_en && pre_spike)  ? (post_trace >> LTD_SHIFT) : '0;
        w_sum  = $signed(SW'(weight)) + $signed(SW'(ltp)) - $signed(SW'(ltd));
        ltp_nz = (ltp != '0);
        ltd_nz = (ltd != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            weight <= WIDTH'(W_INIT);
        else if (wr_hit)
            weight <= clamp($signed(SW'(wr_data)));
        else if (learn_en && (pre_spike || post_spike))
            weight <= clamp(w_sum);
    end
endmodule

module stdp_synapse_array #(
    parameter int N_PRE       = 4,
    parameter int WIDTH       = 8,
    parameter int TRACE_W     = 8,
    parameter int TRACE_INC   = 64,
    parameter int DECAY_SHIFT = 2,
    parameter int LTP_SHIFT   = 3,
    parameter int LTD_SHIFT   = 3,
    parameter int W_MIN       = 4,
    parameter int W_MAX       = 127,
    parameter int W_INIT      = 16,
    localparam int IDX_W      = (N_PRE > 1) ? $clog2(N_PRE) : 1,
    localparam int ISW        = WIDTH + $clog2(N_PRE)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               learn_en,
    input  logic [N_PRE-1:0]   pre_spike,
    input  logic               post_spike,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [WIDTH-1:0]   rd_weight,
    output logic [ISW-1:0]     i_syn,
    output logic               ltp_evt,
    output logic               ltd_evt
);
    logic [N_PRE-1:0][WIDTH-1:0]   weight;
    logic [N_PRE-1:0][TRACE_W-1:0] pre_trace;
    logic [TRACE_W-1:0]            post_trace;
    logic [N_PRE-1:0]              wr_hit;
    logic [N_PRE-1:0]              ltp_nz;
    logic [N_PRE-1:0]              ltd_nz;
    logic [ISW-1:0]                syn_sum;

    stdp_trace #(
        .TRACE_W    (TRACE_W),
        .TRACE_INC  (TRACE_INC),
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_post_trace (
        .clk    (clk),
        .reset_n(reset_n),
        .spike  (post_spike),
        .trace  (post_trace)
    );

    for (genvar k = 0; k < N_PRE; k++) begin : g_lane
        assign wr_hit[k] = wr_en && (wr_idx == IDX_W'(k));

        stdp_lane #(
            .WIDTH      (WIDTH),
            .TRACE_W    (TRACE_W),
            .TRACE_INC  (TRACE_INC),
            .DECAY_SHIFT(DECAY_SHIFT),
            .LTP_SHIFT  (LTP_SHIFT),
            .LTD_SHIFT  (LTD_SHIFT),
            .W_MIN      (W_MIN),
            .W_MAX      (W_MAX),
            .W_INIT     (W_INIT)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .learn_en  (learn_en),
            .pre_spike (pre_spike[k]),
            .post_spike(post_spike),
            .post_trace(post_trace),
            .wr_hit    (wr_hit[k]),
            .wr_data   (wr_data),
            .weight    (weight[k]),
            .pre_trace (pre_trace[k]),
            .ltp_nz    (ltp_nz[k]),
            .ltd_nz    (ltd_nz[k])
        );
    end

    // current uses the weights as they stood before this edge's learning
    always_comb begin
        syn_sum = '0;
        for (int k = 0; k < N_PRE; k++)
            if (pre_spike[k]) syn_sum = syn_sum + ISW'(weight[k]);
    end

    always_comb begin
        rd_weight = '0;
        for (int k = 0; k < N_PRE; k++)
            if (rd_idx == IDX_W'(k)) rd_weight = weight[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_syn   <= '0;
            ltp_evt <= 1'b0;
            ltd_evt <= 1'b0;
        end else begin
            i_syn   <= syn_sum;
            ltp_evt <= |ltp_nz;
            ltd_evt <= |ltd_nz;
        end
    end
endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed bench for stdp_synapse_array with hand-computed expectations.

module tb_stdp_synapse_array;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       learn_en;
    logic [3:0] pre_spike;
    logic       post_spike;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic [1:0] rd_idx;
    logic [7:0] rd_weight;
    logic [9:0] i_syn;
    logic       ltp_evt;
    logic       ltd_evt;

    int n_chk = 0;
    int n_err = 0;

    int exp_tr[17] = '{64, 48, 36, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    int exp_b2b[4] = '{64, 128, 192, 255};

    stdp_synapse_array dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .learn_en  (learn_en),
        .pre_spike (pre_spike),
        .post_spike(post_spike),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_idx    (rd_idx),
        .rd_weight (rd_weight),
        .i_syn     (i_syn),
        .ltp_evt   (ltp_evt),
        .ltd_evt   (ltd_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_w(input string tag, input int idx, input int exp);
        rd_idx = 2'(idx);
        #1;
        chk(tag, int'(rd_weight), exp);
    endtask

    task automatic idle();
        pre_spike  = '0;
        post_spike = 1'b0;
        wr_en      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        idle();
        learn_en = 1'b1;
        wr_idx   = '0;
        wr_data  = '0;
        rd_idx   = '0;
        @(negedge clk);
        reset_n  = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        learn_en = 1'b1;
        idle();
        wr_idx = '0; wr_data = '0; rd_idx = '0;
        #12;
        do_reset();

        // clean reset state
        for (int k = 0; k < 4; k++) chk_w($sformatf("rst_w%0d", k), k, 16);
        chk("rst_isyn", int'(i_syn), 0);
        chk("rst_ltp", int'(ltp_evt), 0);
        chk("rst_ltd", int'(ltd_evt), 0);
        chk("rst_pretr", int'(dut.pre_trace[0]), 0);
        chk("rst_posttr", int'(dut.post_trace), 0);

        // pre then post -> potentiation
        pre_spike = 4'b0001; tick(); idle();
        chk("ltp_isyn", int'(i_syn), 16);
        post_spike = 1'b1; tick(); idle();
        chk_w("ltp_w0", 0, 24);
        chk("ltp_evt", int'(ltp_evt), 1);
        chk("ltp_noltd", int'(ltd_evt), 0);
        chk("isyn_none", int'(i_syn), 0);
        tick();
        chk("ltp_pulse", int'(ltp_evt), 0);

        // post then pre -> depression, then all-channel current
        do_reset();
        post_spike = 1'b1; tick(); idle();
        pre_spike = 4'b0010; tick(); idle();
        chk_w("ltd_w1", 1, 8);
        chk("ltd_evt", int'(ltd_evt), 1);
        pre_spike = 4'b1111; tick(); idle();
        chk("isyn_all", int'(i_syn), 56);
        chk_w("ltd6_w0", 0, 10);
        chk_w("ltd_clmp_w1", 1, 4);

        // clamping at both bounds
        do_reset();
        wr_en = 1'b1; wr_idx = 2'd2; wr_data = 8'd125; pre_spike = 4'b0100;
        tick(); idle();
        chk_w("wr_w2", 2, 125);
        post_spike = 1'b1; tick(); idle();
        chk_w("clmp_hi_w2", 2, 127);
        chk_w("noltp_w0", 0, 16);
        do_reset();
        wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'd5; post_spike = 1'b1;
        tick(); idle();
        chk_w("wr_w3", 3, 5);
        pre_spike = 4'b1000; tick(); idle();
        chk_w("clmp_lo_w3", 3, 4);
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'd200; tick(); idle();
        chk_w("wr_clmp_hi", 0, 127);
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'd0; tick(); idle();
        chk_w("wr_clmp_lo", 1, 4);

        // trace decay and saturation
        do_reset();
        pre_spike = 4'b0001; tick(); idle();
        chk("trace0", int'(dut.pre_trace[0]), exp_tr[0]);
        for (int i = 1; i < 17; i++) begin
            tick();
            chk($sformatf("trace%0d", i), int'(dut.pre_trace[0]), exp_tr[i]);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pre_spike = 4'b0001; tick();
            chk($sformatf("b2b%0d", i), int'(dut.pre_trace[0]), exp_b2b[i]);
        end
        idle();

        // learning disabled: traces move, weights do not
        do_reset();
        learn_en = 1'b0;
        pre_spike = 4'b0001; tick(); idle();
        post_spike = 1'b1; tick(); idle();
        chk_w("nolearn_w0", 0, 16);
        chk("nolearn_evt", int'(ltp_evt), 0);
        chk("nolearn_tr", int'(dut.pre_trace[0]), 48);
        learn_en = 1'b1;

        // write wins on its channel, neighbour still learns
        do_reset();
        pre_spike = 4'b0011; tick(); idle();
        post_spike = 1'b1; wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'd50;
        tick(); idle();
        chk_w("wrwin_w0", 0, 24);
        chk_w("wrwin_w1", 1, 50);

        // asynchronous reset mid-activity
        pre_spike = 4'b1111; post_spike = 1'b1; tick();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) chk_w($sformatf("mid_w%0d", k), k, 16);
        chk("mid_isyn", int'(i_syn), 0);
        chk("mid_ltp", int'(ltp_evt), 0);
        chk("mid_ltd", int'(ltd_evt), 0);
        chk("mid_pretr", int'(dut.pre_trace[1]), 0);
        chk("mid_posttr", int'(dut.post_trace), 0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        post_spike = 1'b1; tick(); idle();
        chk_w("post_rst_w0", 0, 16);
        chk("post_rst_ltp", int'(ltp_evt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end
endmodule

// File: doc/stdp_synapse_array.md
STDP_SYNAPSE_ARRAY -- requirements
Module: stdp_synapse_array

Interface
REQ-001 SHALL have parameter N_PRE, default 4, number of presynaptic channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, weight width (unsigned).
REQ-003 SHALL have parameter TRACE_W, default 8, trace width (unsigned).
REQ-004 SHALL have parameter TRACE_INC, default 64, trace increment per spike.
REQ-005 SHALL have parameter DECAY_SHIFT, default 2, trace decay shift.
REQ-006 SHALL have parameters LTP_SHIFT, default 3, and LTD_SHIFT, default 3, learning-rate shifts.
REQ-007 SHALL have parameters W_MIN, default 4; W_MAX, default 127; W_INIT, default 16.
REQ-008 SHALL have port clk  input  1  clock, rising edge.
REQ-009 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port learn_en  input  1  enables STDP weight updates.
REQ-011 SHALL have port pre_spike  input  N_PRE  one presynaptic spike bit per channel.
REQ-012 SHALL have port post_spike  input  1  postsynaptic spike.
REQ-013 SHALL have ports wr_en  input  1; wr_idx  input  clog2(N_PRE); wr_data  input  WIDTH -- host weight write.
REQ-014 SHALL have ports rd_idx  input  clog2(N_PRE); rd_weight  output  WIDTH -- combinational weight readback.
REQ-015 SHALL have port i_syn  output  WIDTH+clog2(N_PRE)  registered summed synaptic current.
REQ-016 SHALL have ports ltp_evt, ltd_evt  output  1  one-cycle pulses, any channel potentiated/depressed this edge.

Function
REQ-017 SHALL keep one pre trace per channel and one post trace, each TRACE_W bits.
REQ-018 On spike: trace <= min(trace + TRACE_INC, 2^TRACE_W-1); spike overrides decay that cycle.
REQ-019 No spike: trace <= trace - (trace>>DECAY_SHIFT); if trace nonzero and shift term is 0, decrement by 1; 0 stays 0.
REQ-020 All learning uses trace and weight values sampled before the current edge's update.
REQ-021 If learn_en and post_spike: channel k gains LTP_k = pre_trace[k]>>LTP_SHIFT.
REQ-022 If learn_en and pre_spike[k]: channel k loses LTD_k = post_trace>>LTD_SHIFT.
REQ-023 Same-edge pre and post on channel k: new w = w + LTP_k - LTD_k, computed signed at WIDTH+2 bits, then clamped.
REQ-024 All updated weights SHALL be clamped to [W_MIN, W_MAX]; no wrap-around.
REQ-025 learn_en=0: weights unchanged by spikes; traces still update.
REQ-026 wr_en: w[wr_idx] <= wr_data clamped to [W_MIN, W_MAX]; write wins over learning on that channel that edge; other channels learn normally.
REQ-027 i_syn SHALL equal, one cycle after the edge sampling pre_spike, sum of pre-update w[k] over set pre_spike[k]; 0 when none; width precludes overflow.
REQ-028 ltp_evt/ltd_evt SHALL pulse the edge after an update where any LTP_k/LTD_k is nonzero with learn_en=1.
REQ-029 rd_weight SHALL reflect w[rd_idx] as registered; out-of-range idx returns 0.

Reset
REQ-030 reset_n low SHALL asynchronously set all weights to W_INIT, all traces to 0, i_syn, ltp_evt, ltd_evt to 0.
REQ-031 Reset mid-operation SHALL discard in-flight updates; first post-release edge behaves as from clean state.

Verification
REQ-032 Reset, defaults -> all rd_weight=16, i_syn=0, traces 0.
REQ-033 learn_en=1, pre_spike[0] at edge t, post_spike at t+1 -> w0=24, ltp_evt=1 after t+1, i_syn=16 after t.
REQ-034 post_spike at t, pre_spike[1] at t+1 -> w1=8, ltd_evt=1; pre[0..3] together -> i_syn=sum of weights.
REQ-035 Write w2=125 then LTP of 8 -> 127; write w3=5 then LTD of 8 -> 4; write 200 -> 127.
REQ-036 Single pre spike then idle -> trace 64,48,36,27,21,16,12,9,7,6,5,4,3,2,1,0,0; four back-to-back spikes -> 64,128,192,255.
REQ-037 wr_en on channel 1 same edge as LTP on channels 0,1 -> w1=wr_data, w0 updated; reset pulse mid-run -> state back to REQ-032.
